instruction_queue: RTL and testbench



---
 rtl/instruction_queue_pkg.sv | 18 +
 rtl/instruction_queue_if.sv | 37 +++
 rtl/instruction_queue_storage.sv | 18 +
 rtl/instruction_queue.sv | 82 ++++++++
 tb/tb_instruction_queue.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_queue_pkg.sv
// instruction_queue_pkg: default widths and the queue entry layout shared by the instruction queue
package instruction_queue_pkg;
  localparam int ADDR_W  = 64;
  localparam int INSN_W  = 32;
  localparam int PID_W   = 20;
  localparam int TID_W   = 16;
  localparam int MAJ_W   = 64;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  typedef struct packed {
    logic [INSN_W-1:0] instruction;
    logic [ADDR_W-1:0] address;
    logic [PID_W-1:0]  pid;
    logic [TID_W-1:0]  tid;
    logic [MAJ_W-1:0]  maj_id;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/instruction_queue_if.sv
// instruction_queue_if: fetch-side push, decoder-side head outputs and queue status
interface instruction_queue_if
  import instruction_queue_pkg::*;
#(
  parameter int addressWidth            = ADDR_W,
  parameter int instructionWidth        = INSN_W,
  parameter int PidSize                 = PID_W,
  parameter int TidSize                 = TID_W,
  parameter int instructionCounterWidth = MAJ_W,
  parameter int ptrWidth                = PTR_W
) ();
  logic                               enable_i;
  logic [instructionWidth-1:0]        instruction_i;
  logic [addressWidth-1:0]            instructionAddress_i;
  logic [PidSize-1:0]                 instructionPid_i;
  logic [TidSize-1:0]                 instructionTid_i;
  logic                               flush_i;
  logic                               stall_i;
  logic                               full_o;
  logic [ptrWidth:0]                  count_o;
  logic                               outputEnable_o;
  logic [instructionWidth-1:0]        instruction_o;
  logic [addressWidth-1:0]            instructionAddress_o;
  logic [PidSize-1:0]                 instructionPid_o;
  logic [TidSize-1:0]                 instructionTid_o;
  logic [instructionCounterWidth-1:0] instructionMajId_o;
  modport master (
    output enable_i, instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i, flush_i, stall_i,
    input  full_o, count_o, outputEnable_o, instruction_o, instructionAddress_o, instructionPid_o,
           instructionTid_o, instructionMajId_o
  );
  modport slave (
    input  enable_i, instruction_i, instructionAddress_i, instructionPid_i, instructionTid_i, flush_i, stall_i,
    output full_o, count_o, outputEnable_o, instruction_o, instructionAddress_o, instructionPid_o,
           instructionTid_o, instructionMajId_o
  );
endinterface

// File: rtl/instruction_queue_storage.sv
// queue_storage: unreset entry array with one tail-addressed write port and one async head read port
module queue_storage #(
  parameter int queueDepth = 8,
  parameter int ptrWidth   = 3,
  parameter int entryWidth = 196
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ptrWidth-1:0]   i_wr_ptr,
  input  logic [entryWidth-1:0] i_wr_data,
  input  logic [ptrWidth-1:0]   i_rd_ptr,
  output logic [entryWidth-1:0] o_rd_data
);
  logic [entryWidth-1:0] r_mem [queueDepth];
  always_ff @(posedge i_clk)
    if (i_wr_en) r_mem[i_wr_ptr] <= i_wr_data;
  assign o_rd_data = r_mem[i_rd_ptr];
endmodule

// File: rtl/instruction_queue.sv
// instruction_queue: fetch-to-decode FIFO that stamps major IDs and presents a registered head to the decoder
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int addressWidth            = ADDR_W,
  parameter int instructionWidth        = INSN_W,
  parameter int PidSize                 = PID_W,
  parameter int TidSize                 = TID_W,
  parameter int instructionCounterWidth = MAJ_W,
  parameter int queueDepth              = DEPTH,
  parameter int ptrWidth                = PTR_W
) (
  input logic               clock_i,
  input logic               reset_i,
  instruction_queue_if.slave q
);
  localparam int entryWidth = instructionWidth + addressWidth + PidSize + TidSize + instructionCounterWidth;
  logic [ptrWidth-1:0]                r_head, r_tail;
  logic [ptrWidth:0]                  r_count;
  logic [instructionCounterWidth-1:0] r_maj_id;
  logic                               r_oe;
  logic [instructionWidth-1:0]        r_insn;
  logic [addressWidth-1:0]            r_addr;
  logic [PidSize-1:0]                 r_pid;
  logic [TidSize-1:0]                 r_tid;
  logic [instructionCounterWidth-1:0] r_maj_out;
  logic                               w_full, w_push, w_pop;
  logic [entryWidth-1:0]              w_rd_entry;
  assign w_full = r_count == (ptrWidth+1)'(queueDepth);
  assign w_push = q.enable_i && !w_full && !q.flush_i;
  assign w_pop  = !q.flush_i && !q.stall_i && r_count != '0;
  queue_storage #(
    .queueDepth(queueDepth),
    .ptrWidth  (ptrWidth),
    .entryWidth(entryWidth)
  ) u_storage (
    .i_clk    (clock_i),
    .i_wr_en  (w_push),
    .i_wr_ptr (r_tail),
    .i_wr_data({q.instruction_i, q.instructionAddress_i, q.instructionPid_i, q.instructionTid_i, r_maj_id}),
    .i_rd_ptr (r_head),
    .o_rd_data(w_rd_entry)
  );
  // flush only drops the valid flag; the data registers keep the last presented entry
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_maj_id  <= '0;
      r_oe      <= 1'b0;
      r_insn    <= '0;
      r_addr    <= '0;
      r_pid     <= '0;
      r_tid     <= '0;
      r_maj_out <= '0;
    end else begin
      if (q.flush_i) begin
        r_oe   <= 1'b0;
        r_head <= r_tail;
      end else if (!q.stall_i) begin
        r_oe <= w_pop;
        if (w_pop) begin
          {r_insn, r_addr, r_pid, r_tid, r_maj_out} <= w_rd_entry;
          r_head <= r_head + ptrWidth'(1);
        end
      end
      r_count <= q.flush_i ? '0 : r_count + (ptrWidth+1)'(w_push) - (ptrWidth+1)'(w_pop);
      if (w_push) begin
        r_tail   <= r_tail + ptrWidth'(1);
        r_maj_id <= r_maj_id + instructionCounterWidth'(1);
      end
    end
  assign q.full_o               = w_full;
  assign q.count_o              = r_count;
  assign q.outputEnable_o       = r_oe;
  assign q.instruction_o        = r_insn;
  assign q.instructionAddress_o = r_addr;
  assign q.instructionPid_o     = r_pid;
  assign q.instructionTid_o     = r_tid;
  assign q.instructionMajId_o   = r_maj_out;
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed and random scenarios against a queue-based reference model
module tb_instruction_queue;
  import instruction_queue_pkg::*;
  logic clock_i = 1'b0;
  logic reset_i = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 clock_i = ~clock_i;
  instruction_queue_if q ();
  instruction_queue dut (.clock_i(clock_i), .reset_i(reset_i), .q(q));
  entry_t      mq[$];
  entry_t      m_out = '0;
  logic        m_oe = 1'b0;
  logic [63:0] m_maj = '0;
  always @(posedge clock_i)
    if (reset_i) begin
      bit push;
      push = q.enable_i && mq.size() < DEPTH && !q.flush_i;
      if (q.flush_i) begin
        mq.delete();
        m_oe = 1'b0;
      end else if (!q.stall_i) begin
        if (mq.size() > 0) begin
          m_out = mq.pop_front();
          m_oe  = 1'b1;
        end else m_oe = 1'b0;
      end
      if (push) begin
        mq.push_back('{q.instruction_i, q.instructionAddress_i, q.instructionPid_i, q.instructionTid_i, m_maj});
        m_maj = m_maj + 64'd1;
      end
    end
  always @(negedge reset_i) begin
    mq.delete();
    m_oe  = 1'b0;
    m_out = '0;
    m_maj = '0;
  end
  function automatic entry_t obs();
    return {q.instruction_o, q.instructionAddress_o, q.instructionPid_o, q.instructionTid_o, q.instructionMajId_o};
  endfunction
  function automatic bit model_ok();
    return obs() === m_out && q.outputEnable_o === m_oe && q.count_o === 4'(mq.size()) && q.full_o === (mq.size() == DEPTH);
  endfunction
  task automatic cyc(input logic en, input logic fl, input logic st, input logic [63:0] addr);
    q.enable_i             = en;
    q.flush_i              = fl;
    q.stall_i              = st;
    q.instruction_i        = $urandom;
    q.instructionAddress_i = addr;
    q.instructionPid_i     = 20'($urandom);
    q.instructionTid_i     = 16'($urandom);
    @(posedge clock_i);
    #1;
  endtask
  task automatic test_reset();
    q.enable_i = 0; q.flush_i = 0; q.stall_i = 0;
    q.instruction_i = '0; q.instructionAddress_i = '0; q.instructionPid_i = '0; q.instructionTid_i = '0;
    repeat (2) @(posedge clock_i);
    #1;
    n_checks++;
    if (obs() !== '0 || q.outputEnable_o !== 1'b0 || q.count_o !== 4'd0 || q.full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: oe=%b cnt=%0d full=%b data=%h, want all zero", q.outputEnable_o, q.count_o, q.full_o, obs());
    end
    @(negedge clock_i) reset_i = 1'b1;
  endtask
  task automatic test_basic();
    logic [63:0] addrs[4] = '{64'h0, 64'h4, 64'h8, 64'h0};
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3, 1'b0, 1'b0, addrs[i % 4]);
      n_checks++;
      if (!model_ok() || (i >= 1 && i <= 3 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== 64'(i - 1)
          || q.instructionAddress_o !== addrs[i - 1])) || (i == 4 && (q.outputEnable_o !== 1'b0 || q.count_o !== 4'd0))) begin
        n_fail++;
        $display("FAIL basic[%0d]: oe=%b maj=%0d addr=%h cnt=%0d, want oe=%b maj=%0d addr=%h cnt=%0d", i, q.outputEnable_o,
                 q.instructionMajId_o, q.instructionAddress_o, q.count_o, m_oe, m_out.maj_id, m_out.address, mq.size());
      end
    end
  endtask
  task automatic test_full();
    logic [63:0] base = m_maj;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 1'b1, {$urandom, $urandom});
      n_checks++;
      if (!model_ok() || (i >= 7 && (q.full_o !== 1'b1 || q.count_o !== 4'd8))) begin
        n_fail++;
        $display("FAIL full_fill[%0d]: cnt=%0d full=%b, want cnt=%0d full=%b", i, q.count_o, q.full_o, mq.size(), mq.size() == DEPTH);
      end
    end
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      n_checks++;
      if (!model_ok() || (i < 8 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== base + 64'(i)))
          || (i == 0 && (q.full_o !== 1'b0 || q.count_o !== 4'd7)) || (i == 8 && q.outputEnable_o !== 1'b0)) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: oe=%b maj=%0d cnt=%0d full=%b, want oe=%b maj=%0d cnt=%0d", i, q.outputEnable_o,
                 q.instructionMajId_o, q.count_o, q.full_o, i < 8, base + 64'(i), 7 - i);
      end
    end
  endtask
  task automatic test_stall();
    logic [63:0] base = m_maj;
    for (int i = 0; i < 13; i++) begin
      cyc(i < 6, 1'b0, i >= 6 && i < 11, {$urandom, $urandom});
      n_checks++;
      if (!model_ok() || (i >= 5 && i <= 10 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== base + 64'd4))
          || (i == 11 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== base + 64'd5))) begin
        n_fail++;
        $display("FAIL stall[%0d]: oe=%b maj=%0d data=%h, want oe=%b maj=%0d data=%h", i, q.outputEnable_o,
                 q.instructionMajId_o, obs(), m_oe, m_out.maj_id, m_out);
      end
    end
  endtask
  task automatic test_flush();
    logic [63:0] base = m_maj;
    for (int i = 0; i < 7; i++) begin
      cyc(i != 6, i == 4, i < 4, {$urandom, $urandom});
      n_checks++;
      if (!model_ok() || (i == 3 && q.count_o !== 4'd4) || (i == 4 && (q.outputEnable_o !== 1'b0 || q.count_o !== 4'd0))
          || (i == 6 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== base + 64'd4))) begin
        n_fail++;
        $display("FAIL flush[%0d]: oe=%b maj=%0d cnt=%0d, want oe=%b maj=%0d cnt=%0d", i, q.outputEnable_o,
                 q.instructionMajId_o, q.count_o, m_oe, m_out.maj_id, mq.size());
      end
    end
  endtask
  task automatic test_wrap();
    logic [63:0] want[3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    @(negedge clock_i);
    force dut.r_maj_id = 64'hFFFF_FFFF_FFFF_FFFE;
    m_maj = 64'hFFFF_FFFF_FFFF_FFFE;
    #1 release dut.r_maj_id;
    for (int i = 0; i < 4; i++) begin
      cyc(i < 3, 1'b0, 1'b0, {$urandom, $urandom});
      n_checks++;
      if (!model_ok() || (i >= 1 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== want[i - 1]))) begin
        n_fail++;
        $display("FAIL wrap[%0d]: oe=%b maj=%h, want oe=%b maj=%h", i, q.outputEnable_o, q.instructionMajId_o, m_oe, m_out.maj_id);
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0, {$urandom, $urandom});
      n_checks++;
      if (!model_ok()) begin
        n_fail++;
        $display("FAIL random[%0d]: oe=%b cnt=%0d full=%b maj=%0d, want oe=%b cnt=%0d maj=%0d", i, q.outputEnable_o,
                 q.count_o, q.full_o, q.instructionMajId_o, m_oe, mq.size(), m_out.maj_id);
      end
    end
  endtask
  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, i >= 2, {$urandom, $urandom});
    n_checks++;
    if (q.full_o !== 1'b1 || q.outputEnable_o !== 1'b1 || q.count_o !== 4'd8) begin
      n_fail++;
      $display("FAIL areset_setup: full=%b oe=%b cnt=%0d, want full=1 oe=1 cnt=8", q.full_o, q.outputEnable_o, q.count_o);
    end
    #3 reset_i = 1'b0;
    #1;
    n_checks++;
    if (obs() !== '0 || q.outputEnable_o !== 1'b0 || q.count_o !== 4'd0 || q.full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL areset: oe=%b cnt=%0d full=%b data=%h, want all zero", q.outputEnable_o, q.count_o, q.full_o, obs());
    end
    @(negedge clock_i) reset_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(i == 0, 1'b0, 1'b0, {$urandom, $urandom});
      n_checks++;
      if (!model_ok() || (i == 1 && (q.outputEnable_o !== 1'b1 || q.instructionMajId_o !== 64'd0))) begin
        n_fail++;
        $display("FAIL areset_resume[%0d]: oe=%b maj=%0d, want oe=%b maj=%0d", i, q.outputEnable_o, q.instructionMajId_o, m_oe, m_out.maj_id);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
